// File: rtl/rotate_left_seq_if.sv
// rotate_left_seq_if
// Request/response bundle for rotate_left_seq.
//   in_valid  / in_ready  : request channel carrying in_data and in_amt
//   out_valid / out_ready : response channel carrying out_data
// Handshake: a word moves on a rising clk edge where valid and ready are
// both high. A source holds valid and its payload until that edge. Ready
// may be high without valid. Neither ready nor valid is derived
// combinationally from the other side of the same channel.
// Modports:
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the rotator itself (drives in_ready, out_valid, out_data)
interface rotate_left_seq_if #(
  parameter int WIDTH = 4,
  parameter int SW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rotate_left_seq.sv
// rotate_left_seq
// Sequential rotate-left: a word is latched on accept and rotated left by
// one bit per clock until the requested amount has been applied, then the
// result is offered on the response channel until it is taken.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : rotate_left_seq_if.slave (request and response channels)
//   busy     : high whenever the FSM is not in IDLE
//   state_o  : current FSM state (0 IDLE, 1 ROT, 2 DONE) for observation
// Timing: a request accepted with amount N presents out_valid in the cycle
// ending at the (N+1)-th rising edge after the accepting edge.
module rotate_left_seq #(
  parameter int WIDTH = 4,
  parameter int SW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rotate_left_seq_if.slave   bus,
  output logic               busy,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [SW-1:0]    count_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // All handshake outputs are registered alongside the state so that
  // in_ready never depends on in_valid and out_valid never on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            work_q     <= bus.in_data;
            count_q    <= bus.in_amt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.in_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ROT;
            end
          end
        end

        ROT: begin
          work_q  <= {work_q[WIDTH-2:0], work_q[WIDTH-1]};
          count_q <= count_q - 1'b1;
          // This edge performs the last rotate step, so the counter lands
          // on zero together with the move to DONE and never goes below.
          if (count_q == SW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          // Result held unchanged until the downstream takes it.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          count_q     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = work_q;
  assign busy          = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// tb_rotate_left_seq
// Self-checking bench for rotate_left_seq: vector table, round trip over
// all values and amounts, output stall, input noise during rotation and
// reset abort. Expected words travel through a scoreboard queue.
module tb_rotate_left_seq;
  localparam int W  = 4;
  localparam int SW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] amt;
    logic [W-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  rotate_left_seq_if #(.WIDTH(W), .SW(SW)) bus ();

  rotate_left_seq #(.WIDTH(W), .SW(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference models, built from a doubled word rather than stepping
  function automatic logic [W-1:0] rotl_model(input logic [W-1:0] d, input logic [SW-1:0] a);
    logic [2*W-1:0] t;
    t = {d, d} << a;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr_model(input logic [W-1:0] d, input logic [SW-1:0] a);
    logic [2*W-1:0] t;
    t = {d, d} >> a;
    return t[W-1:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // driver: offer one request, push its expected result on acceptance
  task automatic drive_req(input logic [W-1:0] d, input logic [SW-1:0] a,
                           input logic [W-1:0] exp_d, input string nm);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check({nm, " accept timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom_range(0, (1 << W) - 1));
    bus.in_amt   = SW'($urandom_range(0, W - 1));
  endtask

  // response side: measure latency, optionally stall, then take the word
  task automatic wait_result(input string nm, input int exp_lat, input int stall, input bit noise);
    int lat;
    logic [W-1:0] exp;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      if (noise) begin
        check({nm, " in_ready while busy"}, 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom_range(0, (1 << W) - 1));
        bus.in_amt   = SW'($urandom_range(0, W - 1));
      end
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check({nm, " out_valid timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({nm, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    exp = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      check({nm, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
      check({nm, " stall out_data"}, 32'(bus.out_data), 32'(exp));
      if (noise) bus.in_data = W'($urandom_range(0, (1 << W) - 1));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check({nm, " in_ready at transfer"}, 32'(bus.in_ready), 32'd0);
    exp = exp_q.pop_front();
    check({nm, " data"}, 32'(bus.out_data), 32'(exp));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check({nm, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({nm, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    check({nm, " busy clear"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 4'b1100, amt: 2'd1, exp_data: 4'b1001, exp_lat: 2};
    vecs[1] = '{data: 4'b1100, amt: 2'd0, exp_data: 4'b1100, exp_lat: 1};
    vecs[2] = '{data: 4'b1100, amt: 2'd2, exp_data: 4'b0011, exp_lat: 3};
    vecs[3] = '{data: 4'b1100, amt: 2'd3, exp_data: 4'b0110, exp_lat: 4};
    vecs[4] = '{data: 4'b0001, amt: 2'd3, exp_data: 4'b1000, exp_lat: 4};
    vecs[5] = '{data: 4'b1011, amt: 2'd1, exp_data: 4'b0111, exp_lat: 2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].data, vecs[i].amt, vecs[i].exp_data, $sformatf("vec%0d", i));
      wait_result($sformatf("vec%0d", i), vecs[i].exp_lat, $urandom_range(0, 2), 1'b0);
    end

    // long stall in DONE
    drive_req(4'b1011, 2'd2, 4'b1110, "stall5");
    wait_result("stall5", 3, 5, 1'b0);

    // in_valid held with changing data while rotating
    drive_req(4'b0110, 2'd3, 4'b0011, "noise");
    wait_result("noise", 4, 2, 1'b1);

    // round trip: right-rotated input comes back as the original value
    for (int v = 0; v < (1 << W); v++) begin
      for (int s = 0; s < W; s++) begin
        drive_req(rotr_model(W'(v), SW'(s)), SW'(s), W'(v), $sformatf("rt v%0d s%0d", v, s));
        wait_result($sformatf("rt v%0d s%0d", v, s), s + 1, 0, 1'b0);
      end
    end

    // model cross-check against a random left rotation
    begin
      logic [W-1:0]  rd;
      logic [SW-1:0] ra;
      rd = W'($urandom_range(0, (1 << W) - 1));
      ra = SW'($urandom_range(0, W - 1));
      drive_req(rd, ra, rotl_model(rd, ra), "rand rotl");
      wait_result("rand rotl", int'(ra) + 1, 1, 1'b0);
    end

    // reset abort during ROT, then accept on the first edge after release
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1100;
    bus.in_amt   = 2'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("abort entered ROT", 32'(state_o), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort out_data", 32'(bus.out_data), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort state", 32'(state_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort hold out_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    bus.in_amt   = 2'd1;
    exp_q.push_back(4'b0010);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("first edge accept busy", 32'(busy), 32'd1);
    check("first edge accept in_ready", 32'(bus.in_ready), 32'd0);
    wait_result("post reset", 2, 0, 1'b0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    $display("FAIL global timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotate_left_seq.md
ROTATE_LEFT_SEQ -- requirements
Module: rotate_left_seq

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (power of two, >= 2).
REQ-002 Parameter SW, default 2, rotate-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; released synchronously to clk.
REQ-005 in_valid  input  1  upstream offers a word and rotate amount.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_data  input  WIDTH  word to be rotated.
REQ-008 in_amt  input  SW  rotate-left amount, 0..WIDTH-1.
REQ-009 out_valid  output  1  result available on out_data.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_data  output  WIDTH  rotated result, registered.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Block SHALL rotate left, one bit position per clock: the inverse of a rotate-right barrel shifter with the same amount.
REQ-014 FSM states: IDLE, ROT, DONE; one-hot or binary encoding at implementer's choice.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, latch in_data into the working register and in_amt into the down-counter.
REQ-016 Accept with in_amt=0: go directly to DONE; out_valid rises the next cycle, out_data equals in_data.
REQ-017 Accept with in_amt=N>0: go to ROT; each ROT cycle, work <= {work[WIDTH-2:0], work[WIDTH-1]} and count <= count-1.
REQ-018 ROT -> DONE on the cycle in which count reaches 0 after the final rotate step.
REQ-019 Latency: out_valid SHALL assert exactly N+1 cycles after the accepting edge, for N = 0..WIDTH-1.
REQ-020 ROT and DONE: in_ready=0; in_valid and in_data are ignored.
REQ-021 DONE: out_valid=1; out_data held stable while out_ready=0 (no change, for any number of stall cycles).
REQ-022 DONE with out_ready=1: go to IDLE; out_valid drops on the next cycle. No same-cycle re-accept (max throughput one word per N+2 cycles).
REQ-023 out_data SHALL reflect the working register at all times; it is valid only while out_valid=1.
REQ-024 Counter width SW; no wrap-around is possible, because the counter is never decremented below 0.
REQ-025 No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, working register=0, count=0.
REQ-027 Output values during reset: in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-028 Reset asserted in ROT or DONE SHALL abort the operation; no out_valid pulse follows reset release.
REQ-029 First accept is possible on the first rising clk edge with rst_n high.

Verification
REQ-030 Accept in_data=4'b1100 with in_amt=1 -> out_valid after 2 cycles, out_data=4'b1001.
REQ-031 Accept 4'b1100 with amounts 0, 2, 3 -> out_data 4'b1100 (1 cycle), 4'b0011 (3 cycles), 4'b0110 (4 cycles).
REQ-032 Round trip: for all 16 values and all 4 amounts, right-rotate the value by s in the model, feed it with in_amt=s -> out_data equals the original value.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable and in_ready stays 0; on release, one transfer occurs, then IDLE.
REQ-034 Pulse rst_n low mid-ROT with in_amt=3 -> outputs immediately at reset values, no stray out_valid; next request (4'b0001, amt 1) -> 4'b0010.
REQ-035 Hold in_valid=1 with changing in_data during ROT -> result unaffected; next accept occurs only after out_valid&out_ready.
